booth_mul_share_arbiter: RTL

//  Shares one pipelined radix-8 Booth multiplier (N-bit signed operands, 2N-bit product) between NREQ requesters.
//  - Round-robin arbitration; one operand pair is issued per cycle.
//  - A tag pipeline tracks each in-flight operation and routes its product back to the requester that issued it.
//  - Sits between systolic-array PE clusters and the shared multiplier instance.

---
 rtl/booth_mul_share_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/booth_mul_share_arbiter.sv
// booth_mul_share_arbiter
// Round-robin front end that shares one pipelined multiplier between NREQ
// requesters. One operand pair is issued per cycle into a registered issue
// stage; a tag pipe of LAT stages follows the multiplier so that each
// product is routed back to the requester that issued it.
module booth_mul_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [2*N-1:0]    mul_prod,
    output logic [NREQ-1:0]   resp_valid,
    output logic [2*N-1:0]    resp_prod,
    output logic              busy,
    output logic [31:0]       op_count
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] rr_ptr;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;

    logic           vld_p0;
    logic [IDW-1:0] id_p0;

    logic [LAT:1]   vld_pipe;
    logic [IDW-1:0] id_pipe [1:LAT];

    // Grant the first valid requester at or after rr_ptr; a grant depends only
    // on req_valid, hold and rr_ptr, never on another requester's ready.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'((int'(rr_ptr) + k) % NREQ);
                end
            end
            if (gnt_any) begin
                req_ready[gnt_id] = 1'b1;
            end
        end
    end

    // Stage 0: capture the granted operands and tag; operands hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            op_count <= '0;
            vld_p0   <= 1'b0;
            id_p0    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            vld_p0 <= gnt_any;
            if (gnt_any) begin
                id_p0    <= gnt_id;
                mul_a    <= req_a[int'(gnt_id)*N +: N];
                mul_b    <= req_b[int'(gnt_id)*N +: N];
                rr_ptr   <= (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + IDW'(1);
                op_count <= op_count + 32'd1;
            end
        end
    end

    // Stages 1..LAT: tag shift register, never stalls, tail lines up with mul_prod.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LAT; s++) begin
                id_pipe[s] <= '0;
            end
        end else begin
            vld_pipe[1] <= vld_p0;
            id_pipe[1]  <= id_p0;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // Response: route the product to the requester named by the tail tag.
    always_comb begin
        resp_valid = '0;
        resp_prod  = '0;
        if (vld_pipe[LAT]) begin
            resp_valid[id_pipe[LAT]] = 1'b1;
            resp_prod                = mul_prod;
        end
    end

    assign busy = vld_p0 | (|vld_pipe);

endmodule
